// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_reader_pkg;

  localparam int RAM_WORD_W     = 16;
  localparam int RAM_PTR_W      = 16;
  localparam int RD_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_stream_reader_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may happen in the same cycle, even when full.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// DMA-style read engine: issues spaced, credit-limited RAM reads and streams the returned words out.
// Optional 2-D (lines x length with pitch) mode is enabled by defining RAM_READER_2D_EN.
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [15:0]           length,
`ifdef RAM_READER_2D_EN
  input  logic [15:0]           lines,
  input  logic [15:0]           pitch,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           mem_addr,
  output logic                  mem_rd_en,
  input  logic [RAM_WORD_W-1:0] mem_data_read,
  input  logic                  mem_data_read_valid,
  output logic [RAM_WORD_W-1:0] out_data,
  output logic                  out_valid,
`ifdef RAM_READER_2D_EN
  output logic                  out_eol,
`endif
  input  logic                  out_ready
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int FLUSH_W = $clog2(RD_LATENCY + 2);
`ifdef RAM_READER_2D_EN
  localparam int FIFO_W  = RAM_WORD_W + 1;
`else
  localparam int FIFO_W  = RAM_WORD_W;
`endif

  state_t               state;
  state_t               state_next;
  logic [RAM_PTR_W-1:0] word_ptr;
  logic [RAM_PTR_W-1:0] next_ptr;
  logic [15:0]          col_left;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     fifo_count;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 fifo_empty;
  logic [FIFO_W-1:0]    push_data;
  logic [FIFO_W-1:0]    pop_data;
  logic                 start_accept;
  logic                 cmd_empty;
  logic                 credit_ok;
  logic                 issue_go;
  logic                 rsp_accept;
  logic                 line_end;
  logic                 last_word;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{base_addr[31:RAM_PTR_W+1], base_addr[0]};

`ifdef RAM_READER_2D_EN
  logic [RAM_PTR_W-1:0] line_base;
  logic [15:0]          line_left;
  logic [15:0]          len_q;
  logic [RAM_PTR_W-1:0] pitch_q;
  logic [15:0]          ret_col;
  logic                 ret_eol;

  assign cmd_empty = (length == '0) || (lines == '0);
  assign last_word = line_end && (line_left == 16'd1);
  assign next_ptr  = line_end ? (line_base + pitch_q) : (word_ptr + 1'b1);
  assign ret_eol   = (ret_col == len_q - 1'b1);
  assign push_data = {ret_eol, mem_data_read};
  assign out_data  = pop_data[RAM_WORD_W-1:0];
  assign out_eol   = pop_data[RAM_WORD_W];
`else
  assign cmd_empty = (length == '0);
  assign last_word = line_end;
  assign next_ptr  = word_ptr + 1'b1;
  assign push_data = mem_data_read;
  assign out_data  = pop_data;
`endif

  assign start_accept = (state == IDLE) && start;
  assign line_end     = (col_left == 16'd1);
  assign credit_ok    = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(FIFO_DEPTH);
  // Spacing reads by checking the previous pulse keeps mem_rd_en from ever staying high.
  assign issue_go     = (state == ISSUE) && !mem_rd_en && (flush_cnt == '0) && credit_ok;
  assign rsp_accept   = mem_data_read_valid && (flush_cnt == '0) && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = cmd_empty ? DONE : ISSUE;
      ISSUE:   if (issue_go && last_word) state_next = DRAIN;
      DRAIN:   if ((outstanding == '0) && fifo_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM pipeline survives reset, so returns are ignored until any pre-reset reads have drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      outstanding <= '0;
      flush_cnt   <= FLUSH_W'(RD_LATENCY + 1);
    end else begin
      mem_rd_en <= issue_go;
      if (issue_go) mem_addr <= {{(31-RAM_PTR_W){1'b0}}, word_ptr, 1'b0};
      if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      case ({issue_go, rsp_accept})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start_accept) begin
      word_ptr  <= base_addr[RAM_PTR_W:1];
      col_left  <= length;
`ifdef RAM_READER_2D_EN
      line_base <= base_addr[RAM_PTR_W:1];
      line_left <= lines;
      len_q     <= length;
      pitch_q   <= pitch;
`endif
    end else if (issue_go) begin
      word_ptr <= next_ptr;
`ifdef RAM_READER_2D_EN
      col_left <= line_end ? len_q : (col_left - 1'b1);
      if (line_end) begin
        line_base <= line_base + pitch_q;
        line_left <= line_left - 1'b1;
      end
`else
      col_left <= col_left - 1'b1;
`endif
    end
  end

`ifdef RAM_READER_2D_EN
  // Returns arrive in issue order, so a column counter on the return side recovers end-of-line.
  always_ff @(posedge clk) begin
    if (start_accept)    ret_col <= '0;
    else if (rsp_accept) ret_col <= ret_eol ? '0 : (ret_col + 1'b1);
  end
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_accept),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  stale_valid_a: assert property (@(posedge clk) disable iff (reset)
    (mem_data_read_valid && (flush_cnt == '0)) |-> (outstanding != '0));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a fixed-latency RAM model; 2-D case runs when RAM_READER_2D_EN is defined.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data_read;
  logic        mem_data_read_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef RAM_READER_2D_EN
  logic [15:0] lines;
  logic [15:0] pitch;
  logic        out_eol;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cnt = 0;
  logic b2b_seen = 1'b0;
  logic prev_rd  = 1'b0;
  logic [31:0] addr_q[$];
  int          cyc_q[$];
  logic [15:0] data_q[$];
  logic        eol_q[$];

  ram_stream_reader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .base_addr           (base_addr),
    .length              (length),
`ifdef RAM_READER_2D_EN
    .lines               (lines),
    .pitch               (pitch),
`endif
    .busy                (busy),
    .done                (done),
    .mem_addr            (mem_addr),
    .mem_rd_en           (mem_rd_en),
    .mem_data_read       (mem_data_read),
    .mem_data_read_valid (mem_data_read_valid),
    .out_data            (out_data),
    .out_valid           (out_valid),
`ifdef RAM_READER_2D_EN
    .out_eol             (out_eol),
`endif
    .out_ready           (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [15:0] p);
    return {p[7:0], p[15:8]} ^ 16'h5A3C;
  endfunction

  // RAM model: three-stage pipeline, never reset, so reads in flight survive a DUT reset.
  logic [2:0]  pv = 3'b000;
  logic [15:0] pd0, pd1, pd2;
  always @(posedge clk) begin
    pv  <= {pv[1:0], mem_rd_en};
    pd0 <= ram_word(mem_addr[16:1]);
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign mem_data_read_valid = pv[2];
  assign mem_data_read       = pd2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      addr_q.push_back(mem_addr);
      cyc_q.push_back(cyc);
    end
    if (mem_rd_en && prev_rd) b2b_seen = 1'b1;
    prev_rd = mem_rd_en;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      data_q.push_back(out_data);
`ifdef RAM_READER_2D_EN
      eol_q.push_back(out_eol);
`else
      eol_q.push_back(1'b0);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    cyc_q.delete();
    data_q.delete();
    eol_q.delete();
    done_cnt = 0;
    b2b_seen = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk); #1;
    base_addr = base;
    length    = len;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  // Compares the logged read addresses and returned words against a word-pointer run.
  task automatic check_run(input string tag, input logic [15:0] ptr0, input int n);
    logic [15:0] p;
    check({tag, "_issues"}, addr_q.size(), n);
    check({tag, "_words"}, data_q.size(), n);
    for (int i = 0; i < n; i++) begin
      p = ptr0 + 16'(i);
      if (i < addr_q.size()) check($sformatf("%s_addr%0d", tag, i), addr_q[i], {15'b0, p, 1'b0});
      if (i < data_q.size()) check($sformatf("%s_data%0d", tag, i), data_q[i], ram_word(p));
    end
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_no_b2b"}, b2b_seen, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
`ifdef RAM_READER_2D_EN
    lines = 16'd1; pitch = 16'd0;
`endif
    repeat (4) @(posedge clk);
    step();
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_rd_en",     mem_rd_en, 1'b0);
    check("rst_mem_addr",  mem_addr,  32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) step();

    // Linear read, free-flowing output: pulses exactly two cycles apart.
    clear_logs();
    out_ready = 1'b1;
`ifdef RAM_READER_2D_EN
    lines = 16'd1;
`endif
    start_xfer(32'h100, 16'd4);
    check("t1_busy_after_start", busy, 1'b1);
    wait_done("t1", 200);
    check_run("t1", 16'h0080, 4);
    for (int i = 1; i < cyc_q.size(); i++) check($sformatf("t1_gap%0d", i), cyc_q[i] - cyc_q[i-1], 2);
    check("t1_busy_low", busy, 1'b0);

    // Stalled output: credit stops issue at the FIFO depth, then the rest flows.
    clear_logs();
    out_ready = 1'b0;
    start_xfer(32'h200, 16'd20);
    repeat (60) step();
    check("t2_stall_issues", addr_q.size(), 8);
    check("t2_stall_valid", out_valid, 1'b1);
    check("t2_stall_busy", busy, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("t2", 400);
    check_run("t2", 16'h0100, 20);

    // Word pointer wraps from 0xFFFF to 0x0000.
    clear_logs();
    start_xfer(32'h1FFFC, 16'd4);
    wait_done("t3", 200);
    check_run("t3", 16'hFFFE, 4);

    // Zero length: done the cycle after start, no reads.
    clear_logs();
    start_xfer(32'h300, 16'd0);
    step();
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b1);
    step();
    check("t4_done_low", done, 1'b0);
    check("t4_busy_low", busy, 1'b0);
    check("t4_no_reads", addr_q.size(), 0);

    // Reset one cycle after a read issue; the stale return must be discarded.
    clear_logs();
    start_xfer(32'h600, 16'd4);
    begin
      int n = 0;
      while (addr_q.size() == 0 && n < 50) begin
        step();
        n++;
      end
    end
    check("t5_first_issue", addr_q.size(), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    base_addr = 32'h400;
    length    = 16'd3;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    repeat (3) step();
    check("t5_flush_no_issue", addr_q.size(), 0);
    wait_done("t5", 200);
    check_run("t5", 16'h0200, 3);

`ifdef RAM_READER_2D_EN
    // Two lines of three words, pitch 64; end-of-line on the 3rd and 6th words.
    clear_logs();
    lines = 16'd2;
    pitch = 16'd64;
    start_xfer(32'h0, 16'd3);
    wait_done("t6", 300);
    check("t6_issues", addr_q.size(), 6);
    check("t6_words", data_q.size(), 6);
    begin
      logic [15:0] exp_ptr [6];
      exp_ptr = '{16'd0, 16'd1, 16'd2, 16'd64, 16'd65, 16'd66};
      for (int i = 0; i < 6; i++) begin
        if (i < addr_q.size()) check($sformatf("t6_addr%0d", i), addr_q[i], {15'b0, exp_ptr[i], 1'b0});
        if (i < data_q.size()) begin
          check($sformatf("t6_data%0d", i), data_q[i], ram_word(exp_ptr[i]));
          check($sformatf("t6_eol%0d", i), eol_q[i], (i == 2 || i == 5));
        end
      end
    end
    check("t6_done_once", done_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
